owl_wr_arb: RTL
===============

# owl_wr_arb

Burst-aware round-robin arbiter that shares one write-bus master port (`bus_w*`) among `NR` DMA write engines, e.g. the per-channel writers of a multi-plane frame DMA. It grants the bus for a whole burst of `len+1` beats. It locks the grant until the last beat is accepted, then rotates priority so that no requester starves. It sits between the `owl_dma_write` instances and the memory-side write port.

## Interface
Parameters:
- `NR`, 3, number of requesters (2..8)
- `AW`, 32, address width
- `DW`, 64, data width
- `BL`, 4, burst-length field width; a burst is `len+1` beats (1..2^BL)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `m_wval`  in  NR  requester beat valid; bit i = requester i
- `m_wrdy`  out  NR  beat accepted for requester i
- `m_wlen`  in  NR*BL  burst length-1, slice i = `[i*BL +: BL]`, sampled at grant
- `m_waddr`  in  NR*AW  beat address, slice i
- `m_wdata`  in  NR*DW  beat data, slice i
- `bus_wrdy`  in  1  downstream ready
- `bus_wval`  out  1  downstream valid
- `bus_wlen`  out  BL  latched length of current burst
- `bus_waddr`  out  AW  granted requester's address (pass-through)
- `bus_wdata`  out  DW  granted requester's data (pass-through)
- `gnt`  out  NR  one-hot current grant, 0 when idle
- `busy`  out  1  high in BURST state

## Operation
- FSM states: IDLE, BURST.
- IDLE behaviour:
  - If any `m_wval[i]` is high, pick the winner: the first set bit searching upward from `ptr`, wrapping modulo NR.
  - At the next edge: `gnt` = one-hot(winner), `len_q` = `m_wlen[winner]`, `beat_cnt` = 0, state becomes BURST.
  - No requests: stay in IDLE.
- BURST datapath, all combinational from grant:
  - `bus_wval = m_wval[g]`.
  - `bus_waddr`/`bus_wdata` = slice g.
  - `bus_wlen = len_q`.
  - `m_wrdy[g] = bus_wrdy`; all other `m_wrdy` bits are 0.
- Beat accept = `bus_wval & bus_wrdy`. Each accept increments `beat_cnt` (BL bits).
- Accept with `beat_cnt == len_q`:
  - last beat; next state is IDLE;
  - `gnt` goes to 0;
  - `ptr` = (g+1) mod NR, with the wrap computed explicitly, not by power-of-2 truncation.
- Grant stays locked for the whole burst:
  - A requester dropping `m_wval` mid-burst only stalls the bus (`bus_wval`=0). The grant is held. There is no timeout.
  - Changes on `m_wlen[g]` after grant are ignored.
- In IDLE, `bus_wval`=0, `m_wrdy`=0, and `bus_waddr`/`bus_wdata`/`bus_wlen` are don't-care (drive 0).
- Ungranted requesters are never acknowledged, whatever `bus_wrdy` is.

## Timing
- Reset values: state=IDLE, `gnt`=0, `busy`=0, `ptr`=0, `beat_cnt`=0, `len_q`=0, `bus_wval`=0, `m_wrdy`=0, `bus_wlen`=0.
- Grant latency is 1 cycle. `m_wval[i]` high in IDLE at edge N gives `gnt`/`bus_wval` at edge N+1. The first beat can be accepted in that cycle.
- Every burst is followed by exactly one IDLE cycle. This holds even when requests are pending and for back-to-back requests from the same requester.
- Minimum cycles per burst is `len+2`. A `len=0` burst takes 2 cycles.
- Simultaneous requests are resolved in one cycle purely by `ptr` order.
- Reset asserted mid-burst:
  - all state returns to reset values at that edge;
  - the partial burst is abandoned;
  - the requester restarts its own burst.
- Full burst count uses `beat_cnt == len_q`. There is no overflow: `len_q`=2^BL-1 gives 2^BL beats.

## Test plan
- Single burst: requester 0, `m_wlen`=3, `bus_wrdy`=1 → `gnt`=001 one cycle after `m_wval`; 4 beats on consecutive cycles with `bus_wlen`=3; `gnt`=000 for one cycle; `ptr`=1.
- Fairness: NR=3, all three request continuously with len=1 → grant order 0,1,2,0,1,2; each burst 2 beats followed by 1 idle cycle; `m_wrdy` never set for an ungranted bit.
- Back-pressure: requester 1, len=7, `bus_wrdy` toggling 1,0,1,0 → exactly 8 accepted beats; data and address match the requester stream in order; `m_wrdy[1]` mirrors `bus_wrdy`.
- Mid-burst stall: requester 2, len=3, `m_wval[2]` dropped for 5 cycles after beat 2 while requester 0 requests → `gnt` stays 100; `bus_wval`=0 during the gap; burst completes with 4 beats; then requester 0 is granted.
- Boundaries: len=0 → 1 beat then IDLE; len=15 (BL=4) → 16 beats; `m_wlen` changed mid-burst → `bus_wlen` unchanged.
- Reset mid-burst: `rst`=1 for 1 cycle after beat 1 of an 8-beat burst → next cycle `gnt`=0, `bus_wval`=0, `ptr`=0; a new request is granted normally.

Source files
------------

// File: rtl/owl_wr_arb.sv
// owl_wr_arb - burst-aware round-robin write-bus arbiter.
//
// Shares one write-bus master port among NR DMA write engines. A winner is
// chosen in IDLE by searching upward (with wrap) from a rotating pointer.
// The grant is then locked for the whole len+1 beat burst. After the last
// beat the arbiter spends exactly one cycle in IDLE and the pointer moves
// past the requester that just finished.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   m_wval     per-requester beat valid
//   m_wrdy     per-requester beat accepted (only the granted bit can be set)
//   m_wlen     per-requester burst length-1, sampled at grant
//   m_waddr    per-requester beat address
//   m_wdata    per-requester beat data
//   bus_wrdy   downstream ready
//   bus_wval   downstream valid
//   bus_wlen   length of the current burst (latched at grant)
//   bus_waddr  granted requester's address
//   bus_wdata  granted requester's data
//   gnt        one-hot current grant, zero when idle
//   busy       high while a burst owns the bus
module owl_wr_arb #(
  parameter int NR = 3,
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int BL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    m_wval,
  output logic [NR-1:0]    m_wrdy,
  input  logic [NR*BL-1:0] m_wlen,
  input  logic [NR*AW-1:0] m_waddr,
  input  logic [NR*DW-1:0] m_wdata,
  input  logic             bus_wrdy,
  output logic             bus_wval,
  output logic [BL-1:0]    bus_wlen,
  output logic [AW-1:0]    bus_waddr,
  output logic [DW-1:0]    bus_wdata,
  output logic [NR-1:0]    gnt,
  output logic             busy
);

  localparam int PW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          state_r;
  logic [NR-1:0]   gnt_r;
  logic            busy_r;
  logic [PW-1:0]   gidx_r;
  logic [PW-1:0]   ptr_r;
  logic [BL-1:0]   beat_cnt_r;
  logic [BL-1:0]   len_q_r;

  logic            win_found_s;
  logic [PW-1:0]   win_idx_s;
  logic [PW:0]     idx_s;
  logic [NR-1:0]   win_oh_s;
  logic [BL-1:0]   win_len_s;
  logic [PW-1:0]   ptr_next_s;
  logic            accept_s;
  logic            last_s;

  assign gnt  = gnt_r;
  assign busy = busy_r;

  // Round-robin search: first requesting index at or above ptr, wrapping modulo NR.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx_s       = '0;
    for (int k = 0; k < NR; k++) begin
      idx_s = {1'b0, ptr_r} + (PW+1)'(k);
      // Explicit wrap so non-power-of-two NR never selects a missing requester.
      if (idx_s >= (PW+1)'(NR)) begin
        idx_s = idx_s - (PW+1)'(NR);
      end else begin
        idx_s = idx_s;
      end
      if (!win_found_s && m_wval[idx_s[PW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_s[PW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot grant and length slice for the selected winner.
  always_comb begin
    win_oh_s  = '0;
    win_len_s = '0;
    for (int i = 0; i < NR; i++) begin
      if (win_idx_s == PW'(i)) begin
        win_oh_s[i] = 1'b1;
        win_len_s   = m_wlen[i*BL +: BL];
      end else begin
        win_oh_s[i] = 1'b0;
      end
    end
  end

  // Bus datapath muxed straight from the locked grant; everything is zero in IDLE.
  always_comb begin
    bus_wval  = 1'b0;
    bus_waddr = '0;
    bus_wdata = '0;
    m_wrdy    = '0;
    for (int i = 0; i < NR; i++) begin
      if ((state_r == ST_BURST) && (gidx_r == PW'(i))) begin
        bus_wval  = m_wval[i];
        bus_waddr = m_waddr[i*AW +: AW];
        bus_wdata = m_wdata[i*DW +: DW];
        m_wrdy[i] = bus_wrdy;
      end else begin
        m_wrdy[i] = 1'b0;
      end
    end
    if (state_r == ST_BURST) begin
      bus_wlen = len_q_r;
    end else begin
      bus_wlen = '0;
    end
  end

  assign accept_s   = bus_wval & bus_wrdy;
  assign last_s     = accept_s && (beat_cnt_r == len_q_r);
  assign ptr_next_s = (gidx_r == PW'(NR-1)) ? '0 : (gidx_r + PW'(1));

  // Arbitration FSM: grant in IDLE, hold the grant until the last beat, then rotate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gnt_r      <= '0;
      busy_r     <= 1'b0;
      gidx_r     <= '0;
      ptr_r      <= '0;
      beat_cnt_r <= '0;
      len_q_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            state_r    <= ST_BURST;
            gnt_r      <= win_oh_s;
            busy_r     <= 1'b1;
            gidx_r     <= win_idx_s;
            len_q_r    <= win_len_s;
            beat_cnt_r <= '0;
          end
        end
        ST_BURST: begin
          if (last_s) begin
            state_r    <= ST_IDLE;
            gnt_r      <= '0;
            busy_r     <= 1'b0;
            ptr_r      <= ptr_next_s;
            beat_cnt_r <= '0;
          end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + BL'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          gnt_r      <= '0;
          busy_r     <= 1'b0;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
